sad_min_search_pipe: RTL and testbench

- Pipelined, parametrised minimum-SAD selector for the motion-estimation core.
- Each valid beat carries one row of N_CAND candidate SADs from the SAD array. The block reduces each row through a registered comparison tree, then folds the row winner into a running minimum across all rows of one search.
- When the last row of the search arrives, the block emits the best SAD and its motion vector (column, row).
- A seed SAD/vector, such as the predictor candidate, initialises each search.

---
 rtl/sad_min_search_pipe_if.sv | 36 +++
 rtl/sad_min_search_pipe.sv | 166 ++++++++++++++++
 tb/tb_sad_min_search_pipe.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sad_min_search_pipe_if.sv
// Beat/result bus of the minimum-SAD selector: one row of candidate SADs in,
// best SAD plus motion vector out.
interface sad_min_search_pipe_if #(
    parameter int unsigned SAD_W  = 18,
    parameter int unsigned OUT_W  = 14,
    parameter int unsigned N_CAND = 16,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned ROW_W  = 4
);
    logic                      in_valid;
    logic                      in_first;
    logic                      in_last;
    logic [ROW_W-1:0]          in_row;
    logic [N_CAND*SAD_W-1:0]   in_sad;
    logic [SAD_W-1:0]          seed_sad;
    logic [IDX_W-1:0]          seed_mv_x;
    logic [ROW_W-1:0]          seed_mv_y;
    logic                      out_valid;
    logic [OUT_W-1:0]          sad_min;
    logic [IDX_W-1:0]          motion_vec_x;
    logic [ROW_W-1:0]          motion_vec_y;

    // Producer side: the SAD array feeding beats, consuming results.
    modport master (
        output in_valid, in_first, in_last, in_row, in_sad,
        output seed_sad, seed_mv_x, seed_mv_y,
        input  out_valid, sad_min, motion_vec_x, motion_vec_y
    );

    // Selector side.
    modport slave (
        input  in_valid, in_first, in_last, in_row, in_sad,
        input  seed_sad, seed_mv_x, seed_mv_y,
        output out_valid, sad_min, motion_vec_x, motion_vec_y
    );
endinterface

// File: rtl/sad_min_search_pipe.sv
// Pipelined minimum-SAD search: a registered compare tree picks each row winner,
// an accumulator folds row winners into the search minimum from a seed.
module sad_min_search_pipe #(
    parameter int unsigned SAD_W  = 18,
    parameter int unsigned OUT_W  = 14,
    parameter int unsigned N_CAND = 16,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned ROW_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sad_min_search_pipe_if.slave  bus
);
    localparam int unsigned LVL    = IDX_W;
    localparam int unsigned TOP    = LVL - 1;
    localparam int unsigned N_NODE = 2 * N_CAND;
    localparam logic [SAD_W-1:0] SAD_ONES = {SAD_W{1'b1}};
    localparam logic [SAD_W-1:0] SAT_LIM  = SAD_W'({OUT_W{1'b1}});

    // Heap-ordered tree: node n has children 2n and 2n+1, leaves sit at N_CAND+k.
    logic [SAD_W-1:0] tree_sad   [1:N_NODE-1];
    logic [IDX_W-1:0] tree_idx   [1:N_NODE-1];
    logic [SAD_W-1:0] node_sad_q [1:N_CAND-1];
    logic [IDX_W-1:0] node_idx_q [1:N_CAND-1];

    // Sideband travelling alongside the tree; stage TOP lines up with the root.
    logic [LVL-1:0]   sb_valid;
    logic             sb_first    [LVL];
    logic             sb_last     [LVL];
    logic [ROW_W-1:0] sb_row      [LVL];
    logic [SAD_W-1:0] sb_seed_sad [LVL];
    logic [IDX_W-1:0] sb_seed_x   [LVL];
    logic [ROW_W-1:0] sb_seed_y   [LVL];

    logic [SAD_W-1:0] acc_sad_q;
    logic [IDX_W-1:0] acc_x_q;
    logic [ROW_W-1:0] acc_y_q;

    logic             out_valid_q;
    logic [OUT_W-1:0] sad_min_q;
    logic [IDX_W-1:0] mv_x_q;
    logic [ROW_W-1:0] mv_y_q;

    logic [SAD_W-1:0] base_sad_c;
    logic [IDX_W-1:0] base_x_c;
    logic [ROW_W-1:0] base_y_c;
    logic [SAD_W-1:0] fold_sad_c;
    logic [IDX_W-1:0] fold_x_c;
    logic [ROW_W-1:0] fold_y_c;
    logic [OUT_W-1:0] fold_sat_c;

    // Flat view of every tree node: registered internals plus live input leaves.
    always_comb begin : tree_view
        for (int n = 1; n < int'(N_NODE); n++) begin
            tree_sad[n] = '0;
            tree_idx[n] = '0;
        end
        for (int n = 1; n < int'(N_CAND); n++) begin
            tree_sad[n] = node_sad_q[n];
            tree_idx[n] = node_idx_q[n];
        end
        for (int k = 0; k < int'(N_CAND); k++) begin
            tree_sad[int'(N_CAND) + k] = bus.in_sad[k*int'(SAD_W) +: SAD_W];
            tree_idx[int'(N_CAND) + k] = IDX_W'(k);
        end
    end

    // Pairwise compare per node; the left (lower-index) child keeps ties.
    always_ff @(posedge clk) begin : tree_regs
        for (int n = 1; n < int'(N_CAND); n++) begin
            if (tree_sad[2*n+1] < tree_sad[2*n]) begin
                node_sad_q[n] <= tree_sad[2*n+1];
                node_idx_q[n] <= tree_idx[2*n+1];
            end else begin
                node_sad_q[n] <= tree_sad[2*n];
                node_idx_q[n] <= tree_idx[2*n];
            end
        end
    end

    always_ff @(posedge clk) begin : sb_valid_pipe
        if (rst) begin
            sb_valid <= '0;
        end else begin
            sb_valid[0] <= bus.in_valid;
            for (int s = 1; s < int'(LVL); s++) begin
                sb_valid[s] <= sb_valid[s-1];
            end
        end
    end

    // Payload of the sideband only matters where its valid is set, so no reset.
    always_ff @(posedge clk) begin : sb_data_pipe
        sb_first[0]    <= bus.in_first;
        sb_last[0]     <= bus.in_last;
        sb_row[0]      <= bus.in_row;
        sb_seed_sad[0] <= bus.seed_sad;
        sb_seed_x[0]   <= bus.seed_mv_x;
        sb_seed_y[0]   <= bus.seed_mv_y;
        for (int s = 1; s < int'(LVL); s++) begin
            sb_first[s]    <= sb_first[s-1];
            sb_last[s]     <= sb_last[s-1];
            sb_row[s]      <= sb_row[s-1];
            sb_seed_sad[s] <= sb_seed_sad[s-1];
            sb_seed_x[s]   <= sb_seed_x[s-1];
            sb_seed_y[s]   <= sb_seed_y[s-1];
        end
    end

    // Fold the row winner into the running minimum (seed on a first beat).
    always_comb begin : fold_logic
        base_sad_c = acc_sad_q;
        base_x_c   = acc_x_q;
        base_y_c   = acc_y_q;
        if (sb_first[TOP]) begin
            base_sad_c = sb_seed_sad[TOP];
            base_x_c   = sb_seed_x[TOP];
            base_y_c   = sb_seed_y[TOP];
        end
        fold_sad_c = base_sad_c;
        fold_x_c   = base_x_c;
        fold_y_c   = base_y_c;
        if (tree_sad[1] < base_sad_c) begin
            fold_sad_c = tree_sad[1];
            fold_x_c   = tree_idx[1];
            fold_y_c   = sb_row[TOP];
        end
        fold_sat_c = (fold_sad_c > SAT_LIM) ? OUT_W'(SAT_LIM) : OUT_W'(fold_sad_c);
    end

    // A closed search leaves the accumulator at all-ones for stray beats.
    always_ff @(posedge clk) begin : acc_stage
        if (rst) begin
            acc_sad_q   <= SAD_ONES;
            acc_x_q     <= '0;
            acc_y_q     <= '0;
            out_valid_q <= 1'b0;
            sad_min_q   <= '0;
            mv_x_q      <= '0;
            mv_y_q      <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (sb_valid[TOP]) begin
                if (sb_last[TOP]) begin
                    acc_sad_q   <= SAD_ONES;
                    acc_x_q     <= '0;
                    acc_y_q     <= '0;
                    out_valid_q <= 1'b1;
                    sad_min_q   <= fold_sat_c;
                    mv_x_q      <= fold_x_c;
                    mv_y_q      <= fold_y_c;
                end else begin
                    acc_sad_q <= fold_sad_c;
                    acc_x_q   <= fold_x_c;
                    acc_y_q   <= fold_y_c;
                end
            end
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.sad_min      = sad_min_q;
    assign bus.motion_vec_x = mv_x_q;
    assign bus.motion_vec_y = mv_y_q;

endmodule

// File: tb/tb_sad_min_search_pipe.sv
// Self-checking bench for sad_min_search_pipe: a search model pushes expected
// results with their due time, a scoreboard task pops them on out_valid.
module tb_sad_min_search_pipe;
    localparam int unsigned SAD_W  = 18;
    localparam int unsigned OUT_W  = 14;
    localparam int unsigned N_CAND = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned PERIOD = 10;
    localparam int unsigned LAT    = 5;

    typedef struct {
        logic [OUT_W-1:0] sad;
        logic [IDX_W-1:0] x;
        logic [ROW_W-1:0] y;
        time              due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sad_min_search_pipe_if #(
        .SAD_W(SAD_W), .OUT_W(OUT_W), .N_CAND(N_CAND), .IDX_W(IDX_W), .ROW_W(ROW_W)
    ) bus ();

    sad_min_search_pipe #(
        .SAD_W(SAD_W), .OUT_W(OUT_W), .N_CAND(N_CAND), .IDX_W(IDX_W), .ROW_W(ROW_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    exp_t exp_q[$];

    logic [SAD_W-1:0] cand [N_CAND];
    logic [SAD_W-1:0] m_sad;
    logic [IDX_W-1:0] m_x;
    logic [ROW_W-1:0] m_y;
    logic [OUT_W-1:0] obs_sad;
    logic [IDX_W-1:0] obs_x;
    logic [ROW_W-1:0] obs_y;

    task automatic model_clear();
        m_sad = '1;
        m_x   = '0;
        m_y   = '0;
        exp_q.delete();
    endtask

    task automatic set_all(input logic [SAD_W-1:0] v);
        for (int k = 0; k < int'(N_CAND); k++) cand[k] = v;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_first = 1'b0;
            bus.in_last  = 1'b0;
        end
    endtask

    // Drive one valid beat and advance the search model.
    task automatic drive_beat(input bit first, input bit last, input logic [ROW_W-1:0] row,
                              input logic [SAD_W-1:0] ssad, input logic [IDX_W-1:0] sx,
                              input logic [ROW_W-1:0] sy);
        logic [SAD_W-1:0] rmin, bsad;
        logic [IDX_W-1:0] rx, bx;
        logic [ROW_W-1:0] by;
        exp_t e;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_first  = first;
        bus.in_last   = last;
        bus.in_row    = row;
        bus.seed_sad  = ssad;
        bus.seed_mv_x = sx;
        bus.seed_mv_y = sy;
        for (int k = 0; k < int'(N_CAND); k++) bus.in_sad[k*int'(SAD_W) +: SAD_W] = cand[k];
        rmin = cand[0];
        rx   = '0;
        for (int k = 1; k < int'(N_CAND); k++) begin
            if (cand[k] < rmin) begin
                rmin = cand[k];
                rx   = IDX_W'(k);
            end
        end
        bsad = first ? ssad : m_sad;
        bx   = first ? sx   : m_x;
        by   = first ? sy   : m_y;
        if (rmin < bsad) begin
            bsad = rmin;
            bx   = rx;
            by   = row;
        end
        if (last) begin
            e.sad = (bsad > SAD_W'(16383)) ? OUT_W'(16383) : OUT_W'(bsad);
            e.x   = bx;
            e.y   = by;
            e.due = $time + LAT * PERIOD;
            exp_q.push_back(e);
            m_sad = '1;
            m_x   = '0;
            m_y   = '0;
        end else begin
            m_sad = bsad;
            m_x   = bx;
            m_y   = by;
        end
    endtask

    // Scoreboard: every pulse must match the head of the queue at its due time.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                pulses++;
                obs_sad = bus.sad_min;
                obs_x   = bus.motion_vec_x;
                obs_y   = bus.motion_vec_y;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out_valid t=%0t sad_min=%0d required=no pulse", $time, bus.sad_min);
                end else begin
                    e = exp_q.pop_front();
                    if ($time !== e.due) begin
                        fails++;
                        $display("FAIL latency got t=%0t required t=%0t", $time, e.due);
                    end
                    tests++;
                    if (bus.sad_min !== e.sad) begin
                        fails++;
                        $display("FAIL sad_min got=%0d required=%0d", bus.sad_min, e.sad);
                    end
                    tests++;
                    if (bus.motion_vec_x !== e.x || bus.motion_vec_y !== e.y) begin
                        fails++;
                        $display("FAIL motion_vec got=(%0d,%0d) required=(%0d,%0d)",
                                 bus.motion_vec_x, bus.motion_vec_y, e.x, e.y);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= $time) begin
                e = exp_q.pop_front();
                tests++;
                fails++;
                $display("FAIL missing_out_valid at t=%0t required sad=%0d", $time, e.sad);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
        bus.in_row = '0; bus.in_sad = '0;
        bus.seed_sad = '0; bus.seed_mv_x = '0; bus.seed_mv_y = '0;
        model_clear();
        repeat (3) @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.sad_min !== '0 || bus.motion_vec_x !== '0 || bus.motion_vec_y !== '0) begin
            fails++;
            $display("FAIL reset_outputs got v=%0b sad=%0d mv=(%0d,%0d) required all 0",
                     bus.out_valid, bus.sad_min, bus.motion_vec_x, bus.motion_vec_y);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_row();
        int p0 = pulses;
        for (int k = 0; k < int'(N_CAND); k++) cand[k] = SAD_W'(100 + k);
        cand[9] = 18'd7;
        drive_beat(1'b1, 1'b1, 4'd3, 18'h3FFFF, 4'd0, 4'd0);
        idle(8);
        tests++;
        if (pulses - p0 !== 1 || obs_sad !== 14'd7 || obs_x !== 4'd9 || obs_y !== 4'd3) begin
            fails++;
            $display("FAIL single_row got pulses=%0d sad=%0d mv=(%0d,%0d) required 1,7,(9,3)",
                     pulses - p0, obs_sad, obs_x, obs_y);
        end
    endtask

    task automatic test_tie_break();
        set_all(18'd200);
        cand[2]  = 18'd50;
        cand[11] = 18'd50;
        drive_beat(1'b1, 1'b1, 4'd0, 18'd50, 4'd5, 4'd6);
        idle(8);
        tests++;
        if (obs_sad !== 14'd50 || obs_x !== 4'd5 || obs_y !== 4'd6) begin
            fails++;
            $display("FAIL tie_seed got sad=%0d mv=(%0d,%0d) required 50,(5,6)", obs_sad, obs_x, obs_y);
        end
        drive_beat(1'b1, 1'b1, 4'd1, 18'd60, 4'd5, 4'd6);
        idle(8);
        tests++;
        if (obs_sad !== 14'd50 || obs_x !== 4'd2 || obs_y !== 4'd1) begin
            fails++;
            $display("FAIL tie_column got sad=%0d mv=(%0d,%0d) required 50,(2,1)", obs_sad, obs_x, obs_y);
        end
    endtask

    task automatic test_multi_row(input int gap);
        logic [SAD_W-1:0] mins [4];
        logic [IDX_W-1:0] cols [4];
        mins[0] = 18'd40; mins[1] = 18'd30; mins[2] = 18'd30; mins[3] = 18'd35;
        cols[0] = 4'd5;   cols[1] = 4'd1;   cols[2] = 4'd0;   cols[3] = 4'd7;
        for (int r = 0; r < 4; r++) begin
            set_all(18'd500);
            cand[cols[r]] = mins[r];
            drive_beat(r == 0, r == 3, ROW_W'(r), 18'd1000, 4'd15, 4'd15);
            if (gap > 0 && r < 3) idle(gap);
        end
        idle(8);
        tests++;
        if (obs_sad !== 14'd30 || obs_x !== 4'd1 || obs_y !== 4'd1) begin
            fails++;
            $display("FAIL multi_row gap=%0d got sad=%0d mv=(%0d,%0d) required 30,(1,1)",
                     gap, obs_sad, obs_x, obs_y);
        end
    endtask

    task automatic test_saturation();
        set_all(18'd30000);
        cand[12] = 18'd20000;
        drive_beat(1'b1, 1'b1, 4'd2, 18'h3FFFF, 4'd0, 4'd0);
        idle(8);
        tests++;
        if (obs_sad !== 14'd16383 || obs_x !== 4'd12 || obs_y !== 4'd2) begin
            fails++;
            $display("FAIL saturation got sad=%0d mv=(%0d,%0d) required 16383,(12,2)", obs_sad, obs_x, obs_y);
        end
    endtask

    task automatic test_back_to_back();
        int p0 = pulses;
        set_all(18'd300);
        cand[4] = 18'd11;
        drive_beat(1'b1, 1'b1, 4'd1, 18'd900, 4'd0, 4'd0);
        set_all(18'd300);
        cand[13] = 18'd22;
        drive_beat(1'b1, 1'b1, 4'd6, 18'd900, 4'd0, 4'd0);
        idle(12);
        tests++;
        if (pulses - p0 !== 2 || obs_sad !== 14'd22 || obs_x !== 4'd13 || obs_y !== 4'd6) begin
            fails++;
            $display("FAIL back_to_back got pulses=%0d sad=%0d mv=(%0d,%0d) required 2,22,(13,6)",
                     pulses - p0, obs_sad, obs_x, obs_y);
        end
        tests++;
        if (bus.sad_min !== 14'd22 || bus.motion_vec_x !== 4'd13 || bus.motion_vec_y !== 4'd6) begin
            fails++;
            $display("FAIL output_hold got sad=%0d mv=(%0d,%0d) required 22,(13,6)",
                     bus.sad_min, bus.motion_vec_x, bus.motion_vec_y);
        end
    endtask

    task automatic test_reset_mid_search();
        int p0;
        set_all(18'd300);
        cand[0] = 18'd100;
        drive_beat(1'b1, 1'b0, 4'd0, 18'd5, 4'd1, 4'd1);
        drive_beat(1'b0, 1'b0, 4'd1, 18'd5, 4'd1, 4'd1);
        p0 = pulses;
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_first = 1'b1;
        bus.in_last  = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.sad_min !== '0 || bus.motion_vec_x !== '0 || bus.motion_vec_y !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs got v=%0b sad=%0d mv=(%0d,%0d) required all 0",
                     bus.out_valid, bus.sad_min, bus.motion_vec_x, bus.motion_vec_y);
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        model_clear();
        idle(12);
        tests++;
        if (pulses !== p0) begin
            fails++;
            $display("FAIL aborted_search got pulses=%0d required=%0d", pulses, p0);
        end
    endtask

    task automatic test_no_search();
        set_all(18'd900);
        cand[3] = 18'd500;
        drive_beat(1'b0, 1'b1, 4'd9, 18'd5, 4'd7, 4'd7);
        idle(8);
        tests++;
        if (obs_sad !== 14'd500 || obs_x !== 4'd3 || obs_y !== 4'd9) begin
            fails++;
            $display("FAIL no_search got sad=%0d mv=(%0d,%0d) required 500,(3,9)", obs_sad, obs_x, obs_y);
        end
        set_all(18'h3FFFF);
        drive_beat(1'b0, 1'b1, 4'd2, 18'd5, 4'd7, 4'd7);
        idle(8);
        tests++;
        if (obs_sad !== 14'd16383 || obs_x !== 4'd0 || obs_y !== 4'd0) begin
            fails++;
            $display("FAIL all_ones got sad=%0d mv=(%0d,%0d) required 16383,(0,0)", obs_sad, obs_x, obs_y);
        end
    endtask

    initial begin
        obs_sad = '0;
        obs_x   = '0;
        obs_y   = '0;
        test_reset();
        fork
            monitor();
        join_none
        test_single_row();
        test_tie_break();
        test_multi_row(0);
        test_multi_row(2);
        test_saturation();
        test_back_to_back();
        test_reset_mid_search();
        test_no_search();
        idle(10);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending results required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
